// File: rtl/mixcolumns_pipe_if.sv
// Stream bundle for mixcolumns_pipe: input offer (state, mode, tag), result
// return (state, tag) and the busy indication.
interface mixcolumns_pipe_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output in_valid, in_data, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, busy
    );

    modport slave (
        input  in_valid, in_data, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, busy
    );
endinterface

// File: rtl/mixcolumns_pipe.sv
// Pipelined AES MixColumns / InvMixColumns / bypass with valid-ready flow control.
// Stage 1 forms per-byte GF products, stage 2 sums them; later stages only delay.
module mixcolumns_pipe #(
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    mixcolumns_pipe_if.slave io
);
    localparam int NS = PIPE_STAGES;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Per input byte, slot k holds the product used by output row (row_in - k) mod 4.
    function automatic logic [511:0] gf_products(input logic [127:0] d, input logic [1:0] mode);
        logic [511:0] p;
        logic [7:0]   b;
        logic [7:0]   x2;
        logic [7:0]   x4;
        logic [7:0]   x8;
        p = '0;
        for (int j = 0; j < 16; j++) begin
            b  = d[8*j +: 8];
            x2 = xtime(b);
            x4 = xtime(x2);
            x8 = xtime(x4);
            case (mode)
                2'b00:   p[32*j +: 32] = {b, b, x2 ^ b, x2};
                2'b01:   p[32*j +: 32] = {x8 ^ b, x8 ^ x4 ^ b, x8 ^ x2 ^ b, x8 ^ x4 ^ x2};
                default: p[32*j +: 32] = {24'h0, b};
            endcase
        end
        return p;
    endfunction

    function automatic logic [127:0] gf_sum(input logic [511:0] p);
        logic [127:0] s;
        int           k;
        s = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                for (int i = 0; i < 4; i++) begin
                    k = (i - r + 4) % 4;
                    s[8*(r+4*c) +: 8] = s[8*(r+4*c) +: 8] ^ p[32*(i+4*c) + 8*k +: 8];
                end
            end
        end
        return s;
    endfunction

    logic [NS-1:0]    vld_q;
    logic [NS:0]      rdy;
    logic [NS-1:0]    vin;
    logic [TAG_W-1:0] tag_q [NS];
    logic [TAG_W-1:0] tin   [NS];
    logic [127:0]     out_q;

    always_comb begin
        rdy[NS] = io.out_ready;
        for (int k = NS - 1; k >= 0; k--) begin
            rdy[k] = !vld_q[k] || rdy[k+1];
        end
    end

    always_comb begin
        vin[0] = io.in_valid;
        tin[0] = io.in_tag;
        for (int k = 1; k < NS; k++) begin
            vin[k] = vld_q[k-1];
            tin[k] = tag_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            for (int k = 0; k < NS; k++) begin
                if (rdy[k]) vld_q[k] <= vin[k];
            end
        end
    end

    // Only the output-facing tag needs a reset value; inner tags are qualified by vld_q.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NS; k++) begin
            if (rdy[k] && vin[k]) tag_q[k] <= tin[k];
        end
        if (rst) tag_q[NS-1] <= '0;
    end

    if (NS == 1) begin : g_single
        always_ff @(posedge clk) begin
            if (rst) begin
                out_q <= '0;
            end else if (rdy[0] && vin[0]) begin
                out_q <= gf_sum(gf_products(io.in_data, io.in_mode));
            end
        end
    end else begin : g_split
        logic [511:0] prod_q;
        logic [127:0] res_q  [NS-1];
        logic [127:0] res_in [NS-1];

        always_comb begin
            res_in[0] = gf_sum(prod_q);
            for (int k = 1; k < NS - 1; k++) begin
                res_in[k] = res_q[k-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rdy[0] && vin[0]) prod_q <= gf_products(io.in_data, io.in_mode);
            for (int k = 0; k < NS - 1; k++) begin
                if (rdy[k+1] && vin[k+1]) res_q[k] <= res_in[k];
            end
            if (rst) res_q[NS-2] <= '0;
        end

        assign out_q = res_q[NS-2];
    end

    assign io.in_ready  = rdy[0];
    assign io.out_valid = vld_q[NS-1];
    assign io.out_data  = out_q;
    assign io.out_tag   = tag_q[NS-1];
    assign io.busy      = |vld_q;
endmodule

// File: tb/tb_mixcolumns_pipe.sv
// Directed bench for mixcolumns_pipe: known AES column/state vectors, mixed-mode
// stalled stream, fill/overlap occupancy and mid-flight reset.
module tb_mixcolumns_pipe;
    localparam int PIPE_STAGES = 2;
    localparam int TAG_W       = 4;

    localparam logic [127:0] ST_A = 128'he598271e_f11141b8_ae52b4e0_305dbfd4;
    localparam logic [127:0] ST_B = 128'h4c260628_7ad3f848_9a19cbe0_e5816604;
    localparam logic [127:0] ST_C = {32'h4c31262d, 32'hd5d4d4d4, 32'h5c220af2, 32'h455313db};
    localparam logic [127:0] ST_D = {32'hf8bd7e4d, 32'hd6d7d5d5, 32'h9d58dc9f, 32'hbca14d8e};
    localparam logic [127:0] ST_6 = {16{8'hc6}};

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mixcolumns_pipe_if #(.TAG_W(TAG_W)) bus ();

    mixcolumns_pipe #(
        .PIPE_STAGES(PIPE_STAGES),
        .TAG_W      (TAG_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Uniform-byte state: every mode maps it to itself.
    function automatic logic [127:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i * 17 + 5);
        return {16{b}};
    endfunction

    task automatic run_one(input string name, input logic [127:0] d, input logic [1:0] m,
                           input logic [TAG_W-1:0] t, input logic [127:0] exp);
        int lat;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_mode   = m;
        bus.in_tag    = t;
        #1;
        check({name, " in_ready"}, 128'(bus.in_ready), 128'd1);
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({name, " latency"}, 128'(lat), 128'(PIPE_STAGES));
        check({name, " data"}, bus.out_data, exp);
        check({name, " tag"}, 128'(bus.out_tag), 128'(t));
        tick();
        check({name, " drained"}, 128'(bus.out_valid), 128'd0);
    endtask

    logic [127:0] s_in   [8];
    logic [127:0] s_exp  [8];
    logic [1:0]   s_mode [8];
    logic [127:0] held_data;
    logic         prev_stall;
    logic         in_fire;
    logic         out_fire;
    int           tx;
    int           rx;
    int           cyc;
    int           acc;
    int           seen;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = 2'b00;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        check("reset out_valid", 128'(bus.out_valid), 128'd0);
        check("reset busy", 128'(bus.busy), 128'd0);
        check("reset in_ready", 128'(bus.in_ready), 128'd1);
        check("reset out_data", bus.out_data, 128'd0);
        check("reset out_tag", 128'(bus.out_tag), 128'd0);
        rst = 1'b0;
        tick();

        run_one("col0 fwd", 128'h455313db, 2'b00, 4'd1, 128'hbca14d8e);
        run_one("col0 inv", 128'hbca14d8e, 2'b01, 4'd2, 128'h455313db);
        run_one("state fwd", ST_A, 2'b00, 4'd3, ST_B);
        run_one("state inv", ST_B, 2'b01, 4'd4, ST_A);
        run_one("cols fwd", ST_C, 2'b00, 4'd5, ST_D);
        run_one("cols inv", ST_D, 2'b01, 4'd6, ST_C);
        run_one("c6 fwd", ST_6, 2'b00, 4'd7, ST_6);
        run_one("c6 inv", ST_6, 2'b01, 4'd8, ST_6);
        run_one("bypass", ST_A, 2'b10, 4'd9, ST_A);
        run_one("reserved", ST_C, 2'b11, 4'd15, ST_C);

        // Mixed-mode stream with out_ready cycling 1,0,0,1.
        s_in   = '{ST_A, ST_B, ST_C, ST_C, ST_D, ST_A, ST_6, ST_6};
        s_mode = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
        s_exp  = '{ST_B, ST_A, ST_C, ST_D, ST_C, ST_A, ST_6, ST_6};
        tx = 0; rx = 0; cyc = 0; prev_stall = 1'b0; held_data = '0;
        while (rx < 8 && cyc < 200) begin
            bus.in_valid = (tx < 8);
            if (tx < 8) begin
                bus.in_data = s_in[tx];
                bus.in_mode = s_mode[tx];
                bus.in_tag  = TAG_W'(tx);
            end
            bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            #1;
            if (prev_stall) begin
                check("stream hold valid", 128'(bus.out_valid), 128'd1);
                check("stream hold data", bus.out_data, held_data);
            end
            if (bus.out_valid) begin
                check("stream data", bus.out_data, s_exp[rx]);
                check("stream tag", 128'(bus.out_tag), 128'(rx));
            end
            in_fire    = bus.in_valid && bus.in_ready;
            out_fire   = bus.out_valid && bus.out_ready;
            prev_stall = bus.out_valid && !bus.out_ready;
            held_data  = bus.out_data;
            tick();
            if (in_fire) tx++;
            if (out_fire) rx++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("stream count", 128'(rx), 128'd8);
        check("stream sent", 128'(tx), 128'd8);
        #1;
        check("stream empty", 128'(bus.busy), 128'd0);

        // Fill with out_ready low, then overlapped accept/drain.
        bus.out_ready = 1'b0;
        acc = 0;
        for (int g = 0; g < 10; g++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = pat(acc);
            bus.in_mode  = 2'b00;
            bus.in_tag   = TAG_W'(acc);
            #1;
            if (!bus.in_ready) break;
            tick();
            acc++;
        end
        check("fill count", 128'(acc), 128'(PIPE_STAGES));
        check("fill in_ready", 128'(bus.in_ready), 128'd0);
        check("fill busy", 128'(bus.busy), 128'd1);
        check("fill out_valid", 128'(bus.out_valid), 128'd1);
        bus.out_ready = 1'b1;
        rx = 0;
        for (int g = 0; g < 4; g++) begin
            bus.in_data = pat(acc);
            bus.in_tag  = TAG_W'(acc);
            #1;
            check("overlap in_ready", 128'(bus.in_ready), 128'd1);
            check("overlap out_valid", 128'(bus.out_valid), 128'd1);
            check("overlap data", bus.out_data, pat(rx));
            check("overlap tag", 128'(bus.out_tag), 128'(rx));
            tick();
            acc++;
            rx++;
        end
        bus.in_valid = 1'b0;
        for (int g = 0; g < 20; g++) begin
            #1;
            if (!bus.out_valid) break;
            check("drain data", bus.out_data, pat(rx));
            check("drain tag", 128'(bus.out_tag), 128'(rx));
            tick();
            rx++;
        end
        check("drain count", 128'(rx), 128'(acc));
        check("drain busy", 128'(bus.busy), 128'd0);

        // Reset with entries in flight and an offer during the reset cycle.
        tick();
        bus.out_ready = 1'b0;
        for (int g = 0; g < 2; g++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = pat(20 + g);
            bus.in_tag   = TAG_W'(g + 10);
            tick();
        end
        check("flight busy", 128'(bus.busy), 128'd1);
        rst          = 1'b1;
        bus.in_data  = pat(30);
        bus.in_tag   = TAG_W'(12);
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("mid rst out_valid", 128'(bus.out_valid), 128'd0);
        check("mid rst busy", 128'(bus.busy), 128'd0);
        check("mid rst in_ready", 128'(bus.in_ready), 128'd1);
        check("mid rst out_data", bus.out_data, 128'd0);
        bus.out_ready = 1'b1;
        seen = 0;
        for (int g = 0; g < 10; g++) begin
            #1;
            if (bus.out_valid) seen++;
            tick();
        end
        check("mid rst discarded", 128'(seen), 128'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
